// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers used by the memory-backed slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Little-endian lane enables for a legal (aligned) access.
  function automatic logic [3:0] byte_en(input logic [1:0] addr, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [1:0] addr, input logic [2:0] size);
    is_illegal = (size > HSIZE_WORD) ||
                 ((size == HSIZE_HALF) && addr[0]) ||
                 ((size == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-wide memory with byte-enabled synchronous write and asynchronous read.
module ahb_slave_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite memory responder: FSM, wait-state counter, access check and lane enables.
module ahb_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  state_e        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [3:0]    wcnt_q, wcnt_d;

  logic        accept;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        unused;

  assign accept = hsel & hready & htrans[1];
  assign unused = ^{hburst, haddr[31:AW+2]};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_DATA;
        else              wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present hreadyout=1, so each can take a new address phase.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = haddr[AW+1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (is_illegal(haddr[1:0], hsize)) begin
            state_d = ST_ERR1;
          end else if (WS != '0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS - 4'd1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  assign mem_we    = (state_q == ST_DATA) && write_q;
  assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;

  ahb_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .be    (byte_en(addr_q[1:0], size_q)),
    .waddr (addr_q[AW+1:2]),
    .wdata (hwdata),
    .raddr (addr_q[AW+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_slave.sv
// Directed bench: a zero-wait slave (u_dut0) and a two-wait slave (u_dut2) on one bus.
module tb_ahb_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        stall;
  logic        hro0, hresp0, hro2, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int tests = 0;
  int fails = 0;

  always #5 hclk = ~hclk;

  assign hready = ~stall & hro0 & hro2;

  ahb_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(hro2), .hresp(hresp2), .hrdata(hrdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle: address-phase controls plus hwdata for the beat in data phase.
  task automatic cyc(input logic s0, input logic s2, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    hsel0 = s0; hsel2 = s2; htrans = tr; hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset = 1'b1; stall = 1'b0; hburst = 3'd0;
    hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; hwrite = 1'b0; hsize = SZ_W;
    htrans = T_IDLE; hwdata = '0;
    #12;
    chk("rst_hro0", {31'd0, hro0}, 32'd1);
    chk("rst_hresp0", {31'd0, hresp0}, 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hro2", {31'd0, hro2}, 32'd1);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Zero-wait write then back-to-back read
    cyc(1, 0, T_NSEQ, 1, SZ_W, 32'h10, 32'h0);
    chk("zw_wr_hro", {31'd0, hro0}, 32'd1);
    cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h10, 32'hDEADBEEF);
    chk("zw_rd_hro", {31'd0, hro0}, 32'd1);
    chk("zw_rd_data", hrdata0, 32'hDEADBEEF);
    cyc(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'h0);
    chk("zw_idle_hrdata", hrdata0, 32'd0);

    // INCR4 write with BUSY between beats 2 and 3, then INCR4 read
    cyc(1, 0, T_NSEQ, 1, SZ_W, 32'h20, 32'h0);
    cyc(1, 0, T_SEQ,  1, SZ_W, 32'h24, 32'd1);
    cyc(1, 0, T_BUSY, 1, SZ_W, 32'h28, 32'd2);
    chk("busy_hro", {31'd0, hro0}, 32'd1);
    chk("busy_hresp", {31'd0, hresp0}, 32'd0);
    cyc(1, 0, T_SEQ,  1, SZ_W, 32'h28, 32'h0);
    cyc(1, 0, T_SEQ,  1, SZ_W, 32'h2C, 32'd3);
    cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h20, 32'd4);
    chk("burst_rd1", hrdata0, 32'd1);
    cyc(1, 0, T_SEQ,  0, SZ_W, 32'h24, 32'h0);
    chk("burst_rd2", hrdata0, 32'd2);
    cyc(1, 0, T_SEQ,  0, SZ_W, 32'h28, 32'h0);
    chk("burst_rd3", hrdata0, 32'd3);
    cyc(1, 0, T_SEQ,  0, SZ_W, 32'h2C, 32'h0);
    chk("burst_rd4", hrdata0, 32'd4);
    chk("burst_hro", {31'd0, hro0}, 32'd1);

    // Unaligned halfword write -> two-cycle ERROR, memory untouched
    cyc(1, 0, T_NSEQ, 1, SZ_H, 32'h21, 32'h0);
    chk("err1_hro", {31'd0, hro0}, 32'd0);
    chk("err1_hresp", {31'd0, hresp0}, 32'd1);
    cyc(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'hFFFFFFFF);
    chk("err2_hro", {31'd0, hro0}, 32'd1);
    chk("err2_hresp", {31'd0, hresp0}, 32'd1);
    cyc(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'hFFFFFFFF);
    chk("err_idle_hresp", {31'd0, hresp0}, 32'd0);
    cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h20, 32'h0);
    chk("err_mem_kept", hrdata0, 32'd1);

    // Deselected NONSEQ write is ignored
    cyc(0, 0, T_NSEQ, 1, SZ_W, 32'h24, 32'h0);
    chk("desel_hro", {31'd0, hro0}, 32'd1);
    chk("desel_hresp", {31'd0, hresp0}, 32'd0);
    cyc(0, 0, T_IDLE, 0, SZ_W, 32'h0, 32'hDEAD0000);
    cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h24, 32'h0);
    chk("desel_mem_kept", hrdata0, 32'd2);
    cyc(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'h0);

    // Foreign wait: selected NONSEQ held off by hready low
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h28, 32'h0);
      chk("stall_hrdata", hrdata0, 32'd0);
      chk("stall_hro", {31'd0, hro0}, 32'd1);
    end
    stall = 1'b0;
    cyc(1, 0, T_NSEQ, 0, SZ_W, 32'h28, 32'h0);
    chk("stall_rd", hrdata0, 32'd3);
    cyc(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'h0);

    // Two-wait slave: word write, byte write, word read
    cyc(0, 1, T_NSEQ, 1, SZ_W, 32'h10, 32'h0);
    chk("ws_w1_hro_a", {31'd0, hro2}, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'hDEADBEEF);
    chk("ws_w1_hro_b", {31'd0, hro2}, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'hDEADBEEF);
    chk("ws_w1_hro_c", {31'd0, hro2}, 32'd1);
    cyc(0, 1, T_NSEQ, 1, SZ_B, 32'h13, 32'hDEADBEEF);
    chk("ws_w2_hro_a", {31'd0, hro2}, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'hA5A5A5A5);
    chk("ws_w2_hro_b", {31'd0, hro2}, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'hA5A5A5A5);
    chk("ws_w2_hro_c", {31'd0, hro2}, 32'd1);
    cyc(0, 1, T_NSEQ, 0, SZ_W, 32'h10, 32'hA5A5A5A5);
    chk("ws_rd_hro_a", {31'd0, hro2}, 32'd0);
    chk("ws_rd_wait_data", hrdata2, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h0);
    chk("ws_rd_hro_b", {31'd0, hro2}, 32'd0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h0);
    chk("ws_rd_hro_c", {31'd0, hro2}, 32'd1);
    chk("ws_rd_data", hrdata2, 32'hA5ADBEEF);

    // Reset in the WAIT cycle of a write to a word known to hold 0
    cyc(0, 1, T_NSEQ, 1, SZ_W, 32'h30, 32'h0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h0);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h0);
    cyc(0, 1, T_NSEQ, 1, SZ_W, 32'h30, 32'h0);
    chk("rstw_wait_hro", {31'd0, hro2}, 32'd0);
    htrans = T_IDLE; hwdata = 32'h12345678;
    hreset = 1'b1;
    #1;
    chk("rstw_hro", {31'd0, hro2}, 32'd1);
    chk("rstw_hresp", {31'd0, hresp2}, 32'd0);
    chk("rstw_hrdata", hrdata2, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    cyc(0, 1, T_NSEQ, 0, SZ_W, 32'h30, 32'h12345678);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h12345678);
    cyc(0, 1, T_IDLE, 0, SZ_W, 32'h0, 32'h12345678);
    chk("rstw_rd_hro", {31'd0, hro2}, 32'd1);
    chk("rstw_rd_data", hrdata2, 32'd0);
    cyc(0, 0, T_IDLE, 0, SZ_W, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
